uart_loader: RTL

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader_pkg.sv | 22 ++
 rtl/uart_loader_rx.sv | 89 ++++++++
 rtl/uart_loader.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package uart_loader_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_MAX_WORDS    = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid / frame_err pulses.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic [7:0] byte_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          byte_valid_q, frame_err_q;

  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign byte_o       = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= rx_i;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (prev_q && !sync2_q) state_q <= RX_START;
        end
        // Half a bit after the falling edge the line must still be low,
        // otherwise it was a glitch.
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q        <= '0;
            byte_valid_q <= sync2_q;
            frame_err_q  <= !sync2_q;
            state_q      <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Program loader: reads a little-endian word count then that many words over
// UART and writes them to program memory at consecutive word addresses.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int MAX_WORDS    = DEF_MAX_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_i,
  input  logic        start_i,
  output logic        wr_en_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  logic       byte_valid, frame_err;
  logic [7:0] rx_byte;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (uart_rx_i),
    .byte_valid_o(byte_valid),
    .frame_err_o (frame_err),
    .byte_o      (rx_byte)
  );

  ld_state_e   state_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] asm_q;
  logic [31:0] asm_d;
  logic [31:0] len_q;
  logic [29:0] word_idx_q;
  logic        wr_en_q;
  logic [31:0] addr_q, data_q;

  // Bytes arrive LSB first, so each new byte enters at the top.
  assign asm_d = {rx_byte, asm_q};

  assign wr_en_o = wr_en_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign busy_o  = (state_q == ST_LEN) || (state_q == ST_DATA);
  assign done_o  = (state_q == ST_DONE);
  assign err_o   = (state_q == ST_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      asm_q      <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            state_q    <= ST_LEN;
            byte_idx_q <= '0;
            word_idx_q <= '0;
          end
        end
        ST_LEN: begin
          if (frame_err) begin
            state_q <= ST_ERR;
          end else if (byte_valid) begin
            asm_q      <= asm_d[31:8];
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'd3) begin
              len_q <= asm_d;
              if (asm_d == 32'd0)                 state_q <= ST_DONE;
              else if (asm_d > 32'(MAX_WORDS))    state_q <= ST_ERR;
              else                                state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (frame_err) begin
            state_q <= ST_ERR;
          end else if (byte_valid) begin
            asm_q      <= asm_d[31:8];
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'd3) begin
              wr_en_q    <= 1'b1;
              addr_q     <= {word_idx_q, 2'b00};
              data_q     <= asm_d;
              word_idx_q <= word_idx_q + 30'd1;
              if ({2'b00, word_idx_q + 30'd1} == len_q) state_q <= ST_DONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
